// File: rtl/multichannel_downsampler_pkg.sv
// Shared types, widths and helper functions for multichannel_downsampler.
package multichannel_downsampler_pkg;

    localparam int max_decimation_dflt = 16;
    localparam int data_width_dflt     = 24;
    localparam int cnt_w_dflt          = $clog2(max_decimation_dflt);

    // Config fields are wide enough for any max_decimation_p up to 255.
    localparam int cfg_field_w = 8;

    typedef struct packed {
        logic [cfg_field_w-1:0] m;
        logic [cfg_field_w-1:0] phase;
        logic [cfg_field_w-1:0] avg_shift;
    } cfg_t;

    function automatic int acc_width(input int data_width, input int cnt_width);
        return data_width + cnt_width + 1;
    endfunction

    function automatic int sanitise_m(input int m, input int max_m);
        if (m == 0) begin
            return 1;
        end
        if (m > max_m) begin
            return max_m;
        end
        return m;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/multichannel_downsampler_counter.sv
// Per-channel phase counter: counts accepted samples modulo M and flags the emit index.
module ds_channel_counter
    import multichannel_downsampler_pkg::*;
#(
    parameter int cnt_w = cnt_w_dflt
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [cfg_field_w-1:0] m,
    input  logic [cfg_field_w-1:0] target,
    output logic                   hit
);

    logic [cnt_w-1:0] cnt;
    logic             last;

    assign last = (cfg_field_w'(cnt) == m - 1'b1);
    assign hit  = (cfg_field_w'(cnt) == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multichannel_downsampler.sv
// TDM multichannel decimator with per-channel phase counters and valid/ready on both sides.
// Define MULTICHANNEL_DOWNSAMPLER_AVG_EN to emit block averages instead of phase-selected samples.
module multichannel_downsampler
    import multichannel_downsampler_pkg::*;
#(
    parameter int data_width_p     = data_width_dflt,
    parameter int nr_of_channels_p = 2,
    parameter int max_decimation_p = max_decimation_dflt,
    parameter int ch_width_p       = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_load,
    input  logic [$clog2(max_decimation_p):0]   cfg_m,
    input  logic [$clog2(max_decimation_p)-1:0] cfg_phase,
    input  logic [$clog2(max_decimation_p):0]   cfg_avg_shift,
    input  logic                                x_valid,
    output logic                                x_ready,
    input  logic [ch_width_p-1:0]               x_ch,
    input  logic [data_width_p-1:0]             x,
    output logic                                y_valid,
    input  logic                                y_ready,
    output logic [ch_width_p-1:0]               y_ch,
    output logic [data_width_p-1:0]             y
);

    localparam int cnt_w = $clog2(max_decimation_p);

    cfg_t                        cfg_q;
    cfg_t                        cfg_d;
    logic                        accept;
    logic                        emit;
    logic [nr_of_channels_p-1:0] advance;
    logic [nr_of_channels_p-1:0] hit;
    logic [cfg_field_w-1:0]      target;
    logic [data_width_p-1:0]     out_data;

    // An emit can only happen on accept, so the output register is never overwritten unread.
    assign x_ready = !y_valid || y_ready;
    assign accept  = x_valid && x_ready;

    always_comb begin
        cfg_d.m         = cfg_field_w'(sanitise_m(int'(cfg_m), max_decimation_p));
        cfg_d.phase     = (cfg_field_w'(cfg_phase) >= cfg_d.m) ? cfg_d.m - 1'b1
                                                               : cfg_field_w'(cfg_phase);
        cfg_d.avg_shift = cfg_field_w'(cfg_avg_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '{m: cfg_field_w'(1), phase: '0, avg_shift: '0};
        end else if (cfg_load) begin
            cfg_q <= cfg_d;
        end
    end

    // A sample arriving with cfg_load is swallowed; out-of-range channels match no counter.
    for (genvar c = 0; c < nr_of_channels_p; c++) begin : g_ch
        assign advance[c] = accept && !cfg_load && (x_ch == ch_width_p'(c));

        ds_channel_counter #(
            .cnt_w(cnt_w)
        ) u_counter (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (cfg_load),
            .advance(advance[c]),
            .m      (cfg_q.m),
            .target (target),
            .hit    (hit[c])
        );
    end

    assign emit = |(advance & hit);

`ifdef MULTICHANNEL_DOWNSAMPLER_AVG_EN
    localparam int acc_w = acc_width(data_width_p, cnt_w);

    logic signed [acc_w-1:0]        acc [nr_of_channels_p];
    logic signed [acc_w-1:0]        acc_sel;
    logic signed [acc_w-1:0]        sum;
    logic signed [acc_w-1:0]        avg;
    logic signed [data_width_p-1:0] x_s;
    logic                           unused_phase;

    assign target       = cfg_q.m - 1'b1;
    assign x_s          = x;
    assign unused_phase = ^cfg_q.phase;

    always_comb begin
        acc_sel = '0;
        for (int c = 0; c < nr_of_channels_p; c++) begin
            if (x_ch == ch_width_p'(c)) begin
                acc_sel = acc[c];
            end
        end
        sum      = acc_sel + acc_w'(x_s);
        avg      = sum >>> cfg_q.avg_shift;
        out_data = data_width_p'(saturate(64'(avg), data_width_p));
    end

    // The block sum restarts on the emitting sample, so the next block begins empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < nr_of_channels_p; c++) begin
                acc[c] <= '0;
            end
        end else if (cfg_load) begin
            for (int c = 0; c < nr_of_channels_p; c++) begin
                acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < nr_of_channels_p; c++) begin
                if (advance[c]) begin
                    acc[c] <= hit[c] ? '0 : sum;
                end
            end
        end
    end
`else
    logic unused_shift;

    assign target       = cfg_q.phase;
    assign out_data     = x;
    assign unused_shift = ^cfg_q.avg_shift;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y       <= '0;
            y_ch    <= '0;
        end else if (emit) begin
            y_valid <= 1'b1;
            y       <= out_data;
            y_ch    <= x_ch;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multichannel_downsampler.sv
// Bench for multichannel_downsampler: directed scenarios plus random traffic checked against
// a sample-index model. Define MULTICHANNEL_DOWNSAMPLER_AVG_EN to exercise the averaging build.
module tb_multichannel_downsampler;

    localparam int DW   = 24;
    localparam int N    = 3;
    localparam int CHW  = 2;
    localparam int MAXD = 16;
    localparam int CW   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_load;
    logic [CW:0]    cfg_m;
    logic [CW-1:0]  cfg_phase;
    logic [CW:0]    cfg_avg_shift;
    logic           x_valid;
    logic           x_ready;
    logic [CHW-1:0] x_ch;
    logic [DW-1:0]  x;
    logic           y_valid;
    logic           y_ready;
    logic [CHW-1:0] y_ch;
    logic [DW-1:0]  y;

    always #5 clk = ~clk;

    multichannel_downsampler #(
        .data_width_p    (DW),
        .nr_of_channels_p(N),
        .max_decimation_p(MAXD),
        .ch_width_p      (CHW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_load     (cfg_load),
        .cfg_m        (cfg_m),
        .cfg_phase    (cfg_phase),
        .cfg_avg_shift(cfg_avg_shift),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_ch         (x_ch),
        .x            (x),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_ch         (y_ch),
        .y            (y)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] ch;
    } exp_t;

    exp_t   pending[$];
    int     model_m;
    int     model_phase;
    int     model_shift;
    int     seen[N];
    longint run_sum[N];
    int     n_checks = 0;
    int     n_fails  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void clearCounts();
        for (int c = 0; c < N; c++) begin
            seen[c]    = 0;
            run_sum[c] = 0;
        end
    endfunction

    function automatic void modelReset();
        pending.delete();
        model_m     = 1;
        model_phase = 0;
        model_shift = 0;
        clearCounts();
    endfunction

    function automatic void modelLoad(input int m, input int p, input int s);
        model_m     = (m == 0) ? 1 : ((m > MAXD) ? MAXD : m);
        model_phase = (p >= model_m) ? model_m - 1 : p;
        model_shift = s;
        clearCounts();
    endfunction

    // Index of a sample within its channel's block is simply its arrival count modulo M.
    function automatic void modelSample(input int ch, input logic [DW-1:0] data);
        int     idx;
        longint v;
        if (ch >= N) return;
        idx = seen[ch] % model_m;
        seen[ch]++;
`ifdef MULTICHANNEL_DOWNSAMPLER_AVG_EN
        run_sum[ch] += longint'($signed(data));
        if (idx == model_m - 1) begin
            v = run_sum[ch] >>> model_shift;
            if (v > (64'sd1 <<< (DW - 1)) - 1) v = (64'sd1 <<< (DW - 1)) - 1;
            if (v < -(64'sd1 <<< (DW - 1)))    v = -(64'sd1 <<< (DW - 1));
            pending.push_back('{data: DW'(v), ch: CHW'(ch)});
            run_sum[ch] = 0;
        end
`else
        v = longint'(data);
        if (idx == model_phase) begin
            pending.push_back('{data: DW'(v), ch: CHW'(ch)});
        end
`endif
    endfunction

    task automatic applyStimulus(input logic v, input int ch, input logic [DW-1:0] d,
                                 input logic yr, input logic ld);
        logic exp_ready;
        @(negedge clk);
        x_valid  = v;
        x_ch     = CHW'(ch);
        x        = d;
        y_ready  = yr;
        cfg_load = ld;
        #1;
        exp_ready = (pending.size() == 0) || yr;
        checkOutput("x_ready", x_ready, exp_ready);
        checkOutput("y_valid", y_valid, pending.size() != 0);
        if (pending.size() != 0) begin
            checkOutput("y", y, pending[0].data);
            checkOutput("y_ch", y_ch, pending[0].ch);
        end
        if (yr && pending.size() != 0) void'(pending.pop_front());
        if (ld) begin
            modelLoad(int'(cfg_m), int'(cfg_phase), int'(cfg_avg_shift));
        end else if (v && exp_ready) begin
            modelSample(ch, d);
        end
    endtask

    task automatic loadConfig(input int m, input int p, input int s, input logic yr);
        cfg_m         = (CW + 1)'(m);
        cfg_phase     = CW'(p);
        cfg_avg_shift = (CW + 1)'(s);
        applyStimulus(1'b0, 0, '0, yr, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b1;
        cfg_load      = 1'b0;
        cfg_m         = '0;
        cfg_phase     = '0;
        cfg_avg_shift = '0;
        x_valid       = 1'b0;
        x_ch          = '0;
        x             = '0;
        y_ready       = 1'b1;
        modelReset();
        #1 rst_n = 1'b0;
        #12;
        checkOutput("reset_y_valid", y_valid, 1'b0);
        checkOutput("reset_y", y, '0);
        checkOutput("reset_y_ch", y_ch, '0);
        checkOutput("reset_x_ready", x_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single channel M=4 phase=0");
        loadConfig(4, 0, 0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 0, DW'(i), 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("[TB] interleaved M=3 phase=2");
        loadConfig(3, 2, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 0, DW'(10 + i), 1'b1, 1'b0);
            applyStimulus(1'b1, 1, DW'(20 + i), 1'b1, 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("[TB] backpressure M=1");
        loadConfig(1, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, DW'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i % 3, DW'(200 + i), 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("[TB] config sanitising and mid-block load");
        loadConfig(0, 3, 0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, DW'(300 + i), 1'b1, 1'b0);
        loadConfig(31, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1, DW'(400 + i), 1'b1, 1'b0);
        loadConfig(4, 1, 0, 1'b1);
        applyStimulus(1'b1, 0, DW'(500), 1'b1, 1'b0);
        applyStimulus(1'b1, 0, DW'(501), 1'b1, 1'b0);
        cfg_m     = 5'd4;
        cfg_phase = 4'd1;
        applyStimulus(1'b1, 0, DW'(555), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, DW'(600 + i), 1'b1, 1'b0);
        loadConfig(1, 0, 0, 1'b1);
        applyStimulus(1'b1, 1, DW'(700), 1'b0, 1'b0);
        loadConfig(2, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("[TB] out-of-range channel");
        loadConfig(2, 0, 0, 1'b1);
        applyStimulus(1'b1, 0, DW'(800), 1'b1, 1'b0);
        applyStimulus(1'b1, 3, DW'(801), 1'b1, 1'b0);
        applyStimulus(1'b1, 0, DW'(802), 1'b1, 1'b0);
        applyStimulus(1'b1, 3, DW'(803), 1'b1, 1'b0);
        applyStimulus(1'b1, 0, DW'(804), 1'b1, 1'b0);
        applyStimulus(1'b1, 2, DW'(805), 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("[TB] asynchronous reset with pending output");
        loadConfig(1, 0, 0, 1'b1);
        applyStimulus(1'b1, 2, DW'(77), 1'b0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_y_valid", y_valid, 1'b0);
        checkOutput("async_reset_y", y, '0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, i, DW'(900 + i), 1'b1, 1'b0);

`ifdef MULTICHANNEL_DOWNSAMPLER_AVG_EN
        $display("[TB] averaging and saturation");
        loadConfig(4, 0, 2, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 0, DW'(4 * i), 1'b1, 1'b0);
        loadConfig(4, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, DW'(24'h7FFFFF), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, DW'(24'h800000), 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                loadConfig(int'($urandom_range(31)), int'($urandom_range(15)),
                           int'($urandom_range(5)), 1'($urandom_range(1)));
            end else begin
                applyStimulus($urandom_range(99) < 70, int'($urandom_range(3)), DW'($urandom),
                              $urandom_range(99) < 75, 1'b0);
            end
        end
        repeat (3) applyStimulus(1'b0, 0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
